// File: rtl/mux16_arbiter_if.sv
// mux16_arbiter_if: bundles the two source channels and the merged output
// channel of mux16_arbiter.
//
// Handshake rule for every channel in this bundle: a word moves when valid
// and ready are both high at a rising clock edge. A source keeps valid high
// until it sees ready. valid must never be derived from ready, and ready may
// depend on valid in the same cycle.
interface mux16_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;

    // View seen by the arbiter itself.
    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_sel, out_valid
    );

    // View seen by whatever drives the sources and drains the output.
    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux16_arbiter.sv
// mux16_arbiter: merges source channels a and b into one registered output
// channel tagged with out_sel (0 = a, 1 = b). Round-robin arbitration, one
// output register, no combinational path from input data to output data.
//
// Optional feature: define MUX16_ARBITER_GRANT_COUNT_EN to add saturating
// per-source transfer counters (a_count, b_count) with a synchronous clear
// input (count_clr).
module mux16_arbiter #(
    parameter int WIDTH     = 16,
    parameter bit FIRST_PRI = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef MUX16_ARBITER_GRANT_COUNT_EN
    input  logic                 count_clr,
    output logic [15:0]          a_count,
    output logic [15:0]          b_count,
`endif
    mux16_arbiter_if.slave       bus
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    // Priority pointer: source that wins the next contended cycle.
    logic             pri_q, pri_d;

    logic             load;
    logic             grant_a;
    logic             grant_b;

    // Grant: only when the output slot is free or draining, never in reset.
    always_comb begin
        load    = !out_valid_q || bus.out_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && load) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = !pri_q;
                grant_b = pri_q;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    // Next-state for the output slot and the priority pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        pri_d       = pri_q;
        if (grant_a) begin
            out_data_d  = bus.a_data;
            out_sel_d   = 1'b0;
            out_valid_d = 1'b1;
            pri_d       = 1'b1;
        end else if (grant_b) begin
            out_data_d  = bus.b_data;
            out_sel_d   = 1'b1;
            out_valid_d = 1'b1;
            pri_d       = 1'b0;
        end else if (load) begin
            // Slot drained (or already empty) with nothing new to load.
            out_valid_d = 1'b0;
        end
    end

    // Output register and priority pointer; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pri_q       <= FIRST_PRI;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            pri_q       <= pri_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

`ifdef MUX16_ARBITER_GRANT_COUNT_EN
    logic [15:0] a_count_q, a_count_d;
    logic [15:0] b_count_q, b_count_d;

    // Saturating transfer counters; clear wins over a same-cycle increment.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (count_clr) begin
            a_count_d = '0;
            b_count_d = '0;
        end else begin
            if (grant_a && (a_count_q != 16'hFFFF)) begin
                a_count_d = a_count_q + 16'd1;
            end
            if (grant_b && (b_count_q != 16'hFFFF)) begin
                b_count_d = b_count_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule
